// File: rtl/btn_step_gen_pkg.sv
// -----------------------------------------------------------------------------
// btn_step_pkg
// Shared definitions for the push-button step generator:
//   - step_state_t : FSM state encoding (IDLE, DELAY, REPEAT)
//   - params_ok()  : elaboration-time legality check of the timing parameters
// No ports (package).
// -----------------------------------------------------------------------------
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } step_state_t;

    // Returns 1 when the parameter set is legal: every interval is at least
    // two cycles (so two pulses can never be adjacent) and the shared timer
    // width can reach the longest terminal count.
    function automatic bit params_ok(
        input int debounce_cycles,
        input int repeat_delay,
        input int repeat_period,
        input int cnt_w
    );
        int longest;
        longest = debounce_cycles;
        if (repeat_delay > longest) begin
            longest = repeat_delay;
        end
        if (repeat_period > longest) begin
            longest = repeat_period;
        end
        if (debounce_cycles < 2 || repeat_delay < 2 || repeat_period < 2) begin
            return 1'b0;
        end
        if (cnt_w < 1) begin
            return 1'b0;
        end
        if (cnt_w < 31 && (longest - 1) >= (1 << cnt_w)) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/btn_step_gen_if.sv
// -----------------------------------------------------------------------------
// btn_step_gen_if
// Signal bundle between a button source / step consumer and btn_step_gen.
//   btn_raw   : raw push-button, asynchronous, 1 = pressed
//   step_en   : single-cycle step pulse (drives the counter's en)
//   btn_level : debounced button level
//   held      : high while auto-repeat is active
// Modports:
//   master : the environment side (drives btn_raw, observes the rest)
//   slave  : the btn_step_gen side
// -----------------------------------------------------------------------------
interface btn_step_gen_if;

    logic btn_raw;
    logic step_en;
    logic btn_level;
    logic held;

    modport master (
        output btn_raw,
        input  step_en,
        input  btn_level,
        input  held
    );

    modport slave (
        input  btn_raw,
        output step_en,
        output btn_level,
        output held
    );

endinterface

// File: rtl/btn_step_gen_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a counting debouncer. The debounced level
// only flips after DEBOUNCE_CYCLES consecutive synchronized samples disagree
// with it; any shorter disagreement run is thrown away.
// Ports:
//   clk       : clock, all updates on the rising edge
//   reset_n   : asynchronous active-low reset
//   btn_raw   : raw button input, asynchronous to clk
//   btn_level : debounced level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronizer: btn_raw is only ever seen through sync2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: cnt measures the current run of disagreement between sync2
    // and the debounced level; agreement at any point restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (sync2 == btn_level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            btn_level <= sync2;
            cnt       <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/btn_step_gen.sv
// -----------------------------------------------------------------------------
// btn_step_gen
// Push-button front end for the mod-6 step counter. Debounces the button and
// issues one registered single-cycle step pulse per press, followed (when
// REPEAT_EN is set) by auto-repeat pulses while the button stays held.
// Because step_en is registered on the rising edge it is stable across the
// falling edge on which the counter samples en.
// Ports:
//   clk     : clock, all updates on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : btn_step_gen_if.slave (btn_raw in; step_en, btn_level, held out)
// -----------------------------------------------------------------------------
module btn_step_gen
    import btn_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int CNT_W           = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    btn_step_gen_if.slave bus
);

    if (!params_ok(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, CNT_W)) begin : g_param_check
        $fatal(1, "btn_step_gen: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD/CNT_W");
    end

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] RT_MAX      = {CNT_W{1'b1}};

    logic             level;
    step_state_t      state_q;
    step_state_t      state_d;
    logic [CNT_W-1:0] rt_q;
    logic [CNT_W-1:0] rt_d;
    logic             pulse_d;
    logic             step_en_q;
    logic             held_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (bus.btn_raw),
        .btn_level (level)
    );

    // State register. step_en and held are registered copies of the next
    // cycle's decision so both change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rt_q      <= '0;
            step_en_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rt_q      <= rt_d;
            step_en_q <= pulse_d;
            held_q    <= (state_d == REPEAT);
        end
    end

    // Next-state logic. Release is checked before any terminal count so a
    // release landing on the terminal cycle always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (level) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!level) begin
                    state_d = IDLE;
                end else if (REPEAT_EN != 0 && rt_q == DELAY_LAST) begin
                    state_d = REPEAT;
                end
            end
            REPEAT: begin
                if (!level) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / timer logic. Without auto-repeat the DELAY timer saturates so
    // it can never wrap and accidentally match a terminal count.
    always_comb begin
        pulse_d = 1'b0;
        rt_d    = rt_q;
        case (state_q)
            IDLE: begin
                if (level) begin
                    pulse_d = 1'b1;
                    rt_d    = '0;
                end
            end
            DELAY: begin
                if (!level) begin
                    rt_d = '0;
                end else if (REPEAT_EN != 0 && rt_q == DELAY_LAST) begin
                    pulse_d = 1'b1;
                    rt_d    = '0;
                end else if (rt_q != RT_MAX) begin
                    rt_d = rt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!level) begin
                    rt_d = '0;
                end else if (rt_q == PERIOD_LAST) begin
                    pulse_d = 1'b1;
                    rt_d    = '0;
                end else begin
                    rt_d = rt_q + CNT_W'(1);
                end
            end
            default: begin
                rt_d = '0;
            end
        endcase
    end

    assign bus.step_en   = step_en_q;
    assign bus.btn_level = level;
    assign bus.held      = held_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// -----------------------------------------------------------------------------
// tb_btn_step_gen
// Directed self-checking bench for btn_step_gen with DEBOUNCE_CYCLES = 4,
// REPEAT_DELAY = 8, REPEAT_PERIOD = 3. dut0 has auto-repeat off, dut1 has it
// on; both see the same button and reset. A small mod-6 counter model samples
// dut0's step_en on the falling edge, as the real counter does.
// -----------------------------------------------------------------------------
module tb_btn_step_gen;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_raw;
    logic ctr_clr;
    int   ctr = 0;

    int n_checks  = 0;
    int n_errors  = 0;
    int pulses0   = 0;
    int pulses1   = 0;
    int lvl_high1 = 0;

    btn_step_gen_if bus0 ();
    btn_step_gen_if bus1 ();

    assign bus0.btn_raw = btn_raw;
    assign bus1.btn_raw = btn_raw;

    btn_step_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (8)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    btn_step_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (8)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    always #5 clk = ~clk;

    // Mod-6 step counter model, sampling en on the falling edge.
    always @(negedge clk) begin
        if (ctr_clr) begin
            ctr <= 0;
        end else if (bus0.step_en) begin
            ctr <= (ctr == 5) ? 0 : ctr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v);
        btn_raw = v;
    endtask

    // One rising edge, then sample 1 time unit later and tally outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus0.step_en) pulses0++;
        if (bus1.step_en) pulses1++;
        if (bus1.btn_level) lvl_high1++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic waitPulse(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus1.step_en) found = 1'b1;
        end
    endtask

    // Offsets from the first pulse at which dut1 pulses when the button is
    // released after offset 30 (btn_level falls at offset 36).
    function automatic bit isExpectedPulse(input int o);
        int offs [11] = '{0, 8, 11, 14, 17, 20, 23, 26, 29, 32, 35};
        for (int i = 0; i < 11; i++) begin
            if (offs[i] == o) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        bit found;
        int p0;
        int p1;
        int l1;
        int exp_ctr [7] = '{1, 2, 3, 4, 5, 0, 1};

        reset_n = 1'b0;
        ctr_clr = 1'b1;
        applyStimulus(1'b0);
        #1;
        ticks(3);
        checkOutput("rst_step_en", bus1.step_en, 1'b0);
        checkOutput("rst_btn_level", bus1.btn_level, 1'b0);
        checkOutput("rst_held", bus1.held, 1'b0);
        checkOutput("rst_step_en0", bus0.step_en, 1'b0);
        reset_n = 1'b1;
        ctr_clr = 1'b0;
        ticks(2);

        $display("[TB] scenario 1: clean press");
        p0 = pulses0;
        applyStimulus(1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput($sformatf("s1_level_e%0d", k), bus0.btn_level, (k >= 6));
            checkOutput($sformatf("s1_step_e%0d", k), bus0.step_en, (k == 7));
        end
        applyStimulus(1'b0);
        for (int k = 11; k <= 16; k++) begin
            tick();
            if (k == 15) checkOutput("s1_level_before_fall", bus0.btn_level, 1'b1);
            if (k == 16) checkOutput("s1_level_fall", bus0.btn_level, 1'b0);
        end
        ticks(4);
        checkOutput("s1_pulse_count", pulses0 - p0, 1);
        checkOutput("s1_held0", bus0.held, 1'b0);
        ticks(6);

        $display("[TB] scenario 2: bounce");
        p0 = pulses0;
        p1 = pulses1;
        l1 = lvl_high1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(((c / 2) % 2) == 0);
            tick();
        end
        applyStimulus(1'b0);
        ticks(10);
        checkOutput("s2_level_high_cycles", lvl_high1 - l1, 0);
        checkOutput("s2_pulses_rep", pulses1 - p1, 0);
        checkOutput("s2_pulses_norep", pulses0 - p0, 0);

        $display("[TB] scenario 3: auto-repeat");
        applyStimulus(1'b1);
        waitPulse(found);
        checkOutput("s3_first_pulse", found, 1'b1);
        for (int o = 1; o <= 45; o++) begin
            tick();
            checkOutput($sformatf("s3_step_o%0d", o), bus1.step_en, isExpectedPulse(o));
            if (o == 7) checkOutput("s3_held_o7", bus1.held, 1'b0);
            if (o == 8) checkOutput("s3_held_o8", bus1.held, 1'b1);
            if (o == 30) applyStimulus(1'b0);
        end
        checkOutput("s3_held_after_release", bus1.held, 1'b0);
        ticks(6);

        $display("[TB] scenario 4a: release coinciding with delay terminal count");
        applyStimulus(1'b1);
        waitPulse(found);
        checkOutput("s4a_first_pulse", found, 1'b1);
        tick();
        applyStimulus(1'b0);
        p1 = pulses1;
        for (int o = 2; o <= 20; o++) begin
            tick();
            if (o == 6) checkOutput("s4a_level_o6", bus1.btn_level, 1'b1);
            if (o == 7) checkOutput("s4a_level_o7", bus1.btn_level, 1'b0);
            if (o == 8) checkOutput("s4a_step_o8", bus1.step_en, 1'b0);
            if (o == 8) checkOutput("s4a_held_o8", bus1.held, 1'b0);
        end
        checkOutput("s4a_pulse_count", pulses1 - p1, 0);
        ticks(4);

        $display("[TB] scenario 4b: release one cycle later");
        applyStimulus(1'b1);
        waitPulse(found);
        checkOutput("s4b_first_pulse", found, 1'b1);
        ticks(2);
        applyStimulus(1'b0);
        p1 = pulses1;
        for (int o = 3; o <= 20; o++) begin
            tick();
            if (o == 8) checkOutput("s4b_step_o8", bus1.step_en, 1'b1);
            if (o == 8) checkOutput("s4b_held_o8", bus1.held, 1'b1);
            if (o == 9) checkOutput("s4b_held_o9", bus1.held, 1'b0);
        end
        checkOutput("s4b_pulse_count", pulses1 - p1, 1);
        ticks(4);

        $display("[TB] scenario 5: reset while held");
        applyStimulus(1'b1);
        waitPulse(found);
        checkOutput("s5_first_pulse", found, 1'b1);
        ticks(10);
        checkOutput("s5_held_before_reset", bus1.held, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("s5_rst_step", bus1.step_en, 1'b0);
        checkOutput("s5_rst_level", bus1.btn_level, 1'b0);
        checkOutput("s5_rst_held", bus1.held, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            checkOutput($sformatf("s5_rst_level_c%0d", k), bus1.btn_level, 1'b0);
            checkOutput($sformatf("s5_rst_step_c%0d", k), bus1.step_en, 1'b0);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput($sformatf("s5_step_e%0d", k), bus1.step_en, (k == 7));
            if (k == 5) checkOutput("s5_level_e5", bus1.btn_level, 1'b0);
            if (k == 6) checkOutput("s5_level_e6", bus1.btn_level, 1'b1);
        end
        applyStimulus(1'b0);
        ticks(12);

        $display("[TB] scenario 6: counter chain");
        ctr_clr = 1'b1;
        tick();
        ctr_clr = 1'b0;
        p0 = pulses0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1);
            ticks(20);
            applyStimulus(1'b0);
            ticks(12);
            checkOutput($sformatf("s6_ctr_press%0d", i + 1), ctr, exp_ctr[i]);
        end
        checkOutput("s6_pulse_count", pulses0 - p0, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
